ps2_host_tx: RTL
================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED LED set, 0xFF reset) to the keyboard.
//  It is the transmit counterpart of the keyboard receive path.
//  Drives the open-drain PS/2 clock and data lines through output-enable pins; the top level ties the pad low when oe=1.
//  Filters the incoming device clock with the same 8-sample all-equal hysteresis used on the receive path.
// PARAMETERS
//  INHIBIT_CYC  10000      cycles clk is held low before the request (100 us @ 100 MHz)
//  FILT_LEN     8          samples that must all agree before the filtered ps2 clock changes level
//  TIMEOUT_CYC  2000000    max cycles between device clock falling edges (20 ms) before abort
// PORTS
//  clk          in   1  system clock
//  rst          in   1  asynchronous, active-high reset
//  tx_data      in   8  byte to send
//  tx_valid     in   1  request; accepted when tx_valid & tx_ready on a rising edge of clk
//  tx_ready     out  1  high only in IDLE
//  ps2_clk_in   in   1  raw PS/2 clock pad level (asynchronous)
//  ps2_data_in  in   1  raw PS/2 data pad level (asynchronous)
//  ps2_clk_oe   out  1  1 = pull PS/2 clock low, 0 = release
//  ps2_data_oe  out  1  1 = pull PS/2 data low, 0 = release
//  busy         out  1  high from accept until return to IDLE
//  done         out  1  one-cycle pulse: byte sent and device ACK (data=0) seen
//  err          out  1  one-cycle pulse: timeout or missing ACK
// BEHAVIOUR
//  Reset (async, active-high):
//   - state=IDLE; both oe=0; tx_ready=1; busy=done=err=0.
//   - Filter shift register and filtered clock preset to all-ones (line idle high), so no spurious edge on release.
//  Input conditioning:
//   - ps2_clk_in: 2-FF synchronizer, then FILT_LEN shift register.
//   - Filtered clock goes to 1 when all samples are 1 and to 0 when all are 0; otherwise it holds.
//   - fall = filtered clock 1->0, registered, one-cycle pulse.
//   - ps2_data_in: 2-FF synchronizer only.
//  All outputs are registered.
//  FSM:
//   - IDLE:
//     - On accept, latch tx_data and the odd parity bit (~^tx_data); tx_ready=0, busy=1.
//     - Next cycle: ps2_clk_oe=1, go to INHIBIT.
//   - INHIBIT:
//     - Hold clock low for INHIBIT_CYC cycles.
//     - Then ps2_data_oe=1 (start bit 0) for one cycle with the clock still low.
//     - Next cycle release the clock (ps2_clk_oe=0) and go to SEND with bit index 0.
//   - SEND: on each fall, drive the next bit (oe = ~bit):
//     - index 0..7 = data LSB first;
//     - index 8 = parity;
//     - index 9 = stop bit (oe=0).
//     - After index 9, go to ACK.
//   - ACK:
//     - On the next fall, sample synchronized data.
//     - If 0, go to WAIT_IDLE; if 1, pulse err and go to IDLE.
//   - WAIT_IDLE:
//     - Wait until filtered clock = 1 and synchronized data = 1.
//     - Then pulse done; busy=0, tx_ready=1.
//  Timeout:
//   - Counter is cleared on entry to SEND and on every fall; it counts in SEND, ACK and WAIT_IDLE.
//   - At TIMEOUT_CYC: both oe=0 immediately, err pulses, return to IDLE.
//  tx_valid while busy is ignored; no queueing. tx_data is only sampled at accept.
//  done and err are never asserted together. Either one is followed by tx_ready=1 in the same cycle.
//  Reset mid-frame: both lines are released asynchronously and no done/err pulse is generated.
// TESTING (bench: PS/2 device model, INHIBIT_CYC=20, FILT_LEN=4, TIMEOUT_CYC=1000, device clock period 200 cycles)
//  1. Send 0xED:
//     - clock held low for 20 cycles, then data low before clock release.
//     - Device samples bits 1,0,1,1,0,1,1,1, parity 1, stop 1; device ACKs.
//     - Result: one done pulse, err never asserted.
//  2. Send 0x01 then 0xFF back to back, tx_valid held high:
//     - Expected parities 0 and 1.
//     - Second byte accepted only after the first done; tx_ready low throughout each frame.
//  3. Device model withholds ACK (data stays 1 at the 11th fall):
//     - err pulses once, both oe=0, tx_ready=1, no done.
//  4. Device stops clocking after bit 3:
//     - err pulses exactly 1000 cycles after the last fall; lines released.
//  5. Inject 2-cycle glitches on ps2_clk_in while it is high:
//     - No extra fall; the frame still completes with correct bits.
//  6. Assert rst during SEND at bit 5:
//     - Both oe=0 in the same cycle, tx_ready=1 after release.
//     - A following 0xF4 sends correctly.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: sends one host-to-device PS/2 byte over open-drain clock/data, with a filtered device clock and a frame timeout
module ps2_host_tx #(
  parameter int INHIBIT_CYC = 10000,
  parameter int FILT_LEN    = 8,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);
  localparam int CMAX = INHIBIT_CYC > TIMEOUT_CYC ? INHIBIT_CYC : TIMEOUT_CYC;
  localparam int CW = $clog2(CMAX + 1);
  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE} state_t;
  state_t state_q, state_d;
  logic [1:0] csync_q, dsync_q;
  logic [FILT_LEN-1:0] filt_q;
  logic fclk_q, fclk_d, fall_q, din;
  logic [9:0] sh_q, sh_d;
  logic [3:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
  logic ready_q, ready_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  // Filtered clock only moves when every sample agrees; a partial run holds the old level.
  assign fclk_d = (&filt_q) | (fclk_q & (|filt_q));
  assign din = dsync_q[1];
  assign tx_ready = ready_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err = err_q;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csync_q   <= '1;
      dsync_q   <= '1;
      filt_q    <= '1;
      fclk_q    <= 1'b1;
      fall_q    <= 1'b0;
      state_q   <= IDLE;
      sh_q      <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      csync_q   <= {csync_q[0], ps2_clk_in};
      dsync_q   <= {dsync_q[0], ps2_data_in};
      filt_q    <= {filt_q[FILT_LEN-2:0], csync_q[1]};
      fclk_q    <= fclk_d;
      fall_q    <= fclk_q & ~fclk_d;
      state_q   <= state_d;
      sh_q      <= sh_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q + CW'(1);
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    ready_d   = ready_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (tx_valid && ready_q) begin
          sh_d     = {1'b1, ~^tx_data, tx_data};
          ready_d  = 1'b0;
          busy_d   = 1'b1;
          clk_oe_d = 1'b1;
          state_d  = INHIBIT;
        end
      end
      INHIBIT: if (cnt_q == CW'(INHIBIT_CYC - 1)) begin
        data_oe_d = 1'b1;
        state_d   = REQ;
      end
      REQ: begin
        clk_oe_d = 1'b0;
        idx_d    = '0;
        cnt_d    = '0;
        state_d  = SEND;
      end
      SEND: if (fall_q) begin
        data_oe_d = ~sh_q[idx_q];
        idx_d     = idx_q + 4'd1;
        state_d   = idx_q == 4'd9 ? ACK : SEND;
      end
      ACK: if (fall_q) begin
        state_d = din ? IDLE : WAIT_IDLE;
        err_d   = din;
        ready_d = din;
        busy_d  = ~din;
      end
      WAIT_IDLE: if (fclk_q && din) begin
        state_d = IDLE;
        done_d  = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    // A stalled device aborts the frame; any fall restarts the window.
    if (state_q inside {SEND, ACK, WAIT_IDLE}) begin
      if (fall_q) cnt_d = '0;
      else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
        state_d   = IDLE;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        err_d     = 1'b1;
        done_d    = 1'b0;
        ready_d   = 1'b1;
        busy_d    = 1'b0;
      end
    end
  end
endmodule
